// File: rtl/timer_counter.sv
// Prescaled down-counter timing stage: IDLE/RUN control with one-shot or
// auto-reload expiry, a one-cycle expiry pulse and a sticky interrupt flag.
module timer_counter #(
    parameter int WIDTH      = 16,
    parameter int PRESCALE_W = 8
) (
    input  logic                  clk,
    input  logic                  clr_b,
    input  logic                  start,
    input  logic                  stop,
    input  logic [WIDTH-1:0]      load_val,
    input  logic [PRESCALE_W-1:0] prescale,
    input  logic                  auto_reload,
    input  logic                  irq_clr,
    output logic [WIDTH-1:0]      count,
    output logic                  running,
    output logic                  expired,
    output logic                  irq
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [WIDTH-1:0]      CNT_ZERO = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0]      CNT_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [PRESCALE_W-1:0] PSC_ZERO = {PRESCALE_W{1'b0}};
    localparam logic [PRESCALE_W-1:0] PSC_ONE  = {{(PRESCALE_W-1){1'b0}}, 1'b1};

    state_t                  state_r;
    state_t                  state_nxt_s;
    logic [WIDTH-1:0]        count_r;
    logic [WIDTH-1:0]        count_nxt_s;
    logic [PRESCALE_W-1:0]   psc_r;
    logic [PRESCALE_W-1:0]   psc_nxt_s;
    logic                    running_r;
    logic                    expired_r;
    logic                    expired_nxt_s;
    logic                    irq_r;
    logic                    irq_nxt_s;

    logic                    load_nz_s;
    logic                    start_ok_s;
    logic                    tick_s;
    logic                    expire_s;
    logic                    reload_s;

    // Decode of the per-edge events shared by the next-state and output logic
    always_comb begin
        load_nz_s  = (load_val != CNT_ZERO);
        start_ok_s = start & load_nz_s;
        // >= (not ==) so a live reduction of prescale cannot overrun the count
        tick_s     = (state_r == RUN) & (psc_r >= prescale);
        expire_s   = tick_s & (count_r == CNT_ONE);
        reload_s   = auto_reload & load_nz_s;
    end

    // State register
    always_ff @(posedge clk or negedge clr_b) begin
        if (!clr_b) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic: stop beats start, start beats the tick
    always_comb begin
        state_nxt_s = state_r;
        if (stop) begin
            state_nxt_s = IDLE;
        end else if (start_ok_s) begin
            state_nxt_s = RUN;
        end else if (start) begin
            state_nxt_s = state_r;
        end else begin
            case (state_r)
                RUN: begin
                    if (expire_s && !reload_s) begin
                        state_nxt_s = IDLE;
                    end else if (tick_s && (count_r == CNT_ZERO)) begin
                        // Unreachable zero count in RUN: park safely without a pulse
                        state_nxt_s = IDLE;
                    end else begin
                        state_nxt_s = RUN;
                    end
                end
                IDLE: begin
                    state_nxt_s = IDLE;
                end
                default: begin
                    state_nxt_s = IDLE;
                end
            endcase
        end
    end

    // Output logic: next values of count, prescaler, expiry pulse and irq
    always_comb begin
        count_nxt_s   = count_r;
        psc_nxt_s     = psc_r;
        expired_nxt_s = 1'b0;
        if (stop) begin
            count_nxt_s = count_r;
            psc_nxt_s   = psc_r;
        end else if (start_ok_s) begin
            count_nxt_s = load_val;
            psc_nxt_s   = PSC_ZERO;
        end else if (start) begin
            count_nxt_s = count_r;
            psc_nxt_s   = psc_r;
        end else begin
            case (state_r)
                RUN: begin
                    if (tick_s) begin
                        psc_nxt_s = PSC_ZERO;
                        if (count_r > CNT_ONE) begin
                            count_nxt_s = count_r - CNT_ONE;
                        end else if (count_r == CNT_ONE) begin
                            expired_nxt_s = 1'b1;
                            count_nxt_s   = reload_s ? load_val : CNT_ZERO;
                        end else begin
                            count_nxt_s = CNT_ZERO;
                        end
                    end else begin
                        psc_nxt_s = psc_r + PSC_ONE;
                    end
                end
                IDLE: begin
                    count_nxt_s = count_r;
                    psc_nxt_s   = psc_r;
                end
                default: begin
                    count_nxt_s = count_r;
                    psc_nxt_s   = psc_r;
                end
            endcase
        end
        // A new expiry wins over a simultaneous clear
        if (expired_nxt_s) begin
            irq_nxt_s = 1'b1;
        end else if (irq_clr) begin
            irq_nxt_s = 1'b0;
        end else begin
            irq_nxt_s = irq_r;
        end
    end

    // Datapath and output registers
    always_ff @(posedge clk or negedge clr_b) begin
        if (!clr_b) begin
            count_r   <= CNT_ZERO;
            psc_r     <= PSC_ZERO;
            running_r <= 1'b0;
            expired_r <= 1'b0;
            irq_r     <= 1'b0;
        end else begin
            count_r   <= count_nxt_s;
            psc_r     <= psc_nxt_s;
            running_r <= (state_nxt_s == RUN);
            expired_r <= expired_nxt_s;
            irq_r     <= irq_nxt_s;
        end
    end

    assign count   = count_r;
    assign running = running_r;
    assign expired = expired_r;
    assign irq     = irq_r;

endmodule

// File: tb/tb_timer_counter.sv
// Scoreboard bench for timer_counter: directed steps push expected outputs,
// a monitor pops and compares after every clock edge or async-reset probe.
module tb_timer_counter;

    logic        clk;
    logic        clr_b;
    logic        start;
    logic        stop;
    logic [15:0] load_val;
    logic [7:0]  prescale;
    logic        auto_reload;
    logic        irq_clr;
    logic [15:0] count;
    logic        running;
    logic        expired;
    logic        irq;

    typedef struct {
        logic [15:0] count;
        logic        running;
        logic        expired;
        logic        irq;
        int          id;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests;
    int   n_failed;
    int   step_id;
    event async_ev;

    timer_counter #(.WIDTH(16), .PRESCALE_W(8)) dut (
        .clk         (clk),
        .clr_b       (clr_b),
        .start       (start),
        .stop        (stop),
        .load_val    (load_val),
        .prescale    (prescale),
        .auto_reload (auto_reload),
        .irq_clr     (irq_clr),
        .count       (count),
        .running     (running),
        .expired     (expired),
        .irq         (irq)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Monitor: compares each presented output against the scoreboard head
    initial begin
        exp_t e;
        forever begin
            @(posedge clk or async_ev);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_tests++;
                if (count !== e.count || running !== e.running ||
                    expired !== e.expired || irq !== e.irq) begin
                    n_failed++;
                    $display("FAIL step%0d: got count=%0d running=%0b expired=%0b irq=%0b, expected count=%0d running=%0b expired=%0b irq=%0b",
                             e.id, count, running, expired, irq,
                             e.count, e.running, e.expired, e.irq);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic step(input logic s, input logic p, input logic c,
                        input logic [15:0] ec, input logic er,
                        input logic ee, input logic ei);
        @(negedge clk);
        start   = s;
        stop    = p;
        irq_clr = c;
        exp_q.push_back('{ec, er, ee, ei, step_id});
        step_id++;
        @(posedge clk);
        #2;
    endtask

    task automatic check_async(input logic [15:0] ec, input logic er,
                               input logic ee, input logic ei);
        exp_q.push_back('{ec, er, ee, ei, step_id});
        step_id++;
        -> async_ev;
        #2;
    endtask

    initial begin
        n_tests = 0; n_failed = 0; step_id = 0;
        start = 1'b0; stop = 1'b0; irq_clr = 1'b0;
        load_val = 16'd0; prescale = 8'd0; auto_reload = 1'b0;
        clr_b = 1'b1;
        #1;
        clr_b = 1'b0;
        check_async(16'd0, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        @(negedge clk);
        clr_b = 1'b1;
        step(1'b0, 1'b0, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0);

        // One-shot, prescale 0, period 5
        load_val = 16'd5;
        step(1'b1, 1'b0, 1'b0, 16'd5, 1'b1, 1'b0, 1'b0);
        for (int i = 4; i >= 1; i--) begin
            step(1'b0, 1'b0, 1'b0, 16'(i), 1'b1, 1'b0, 1'b0);
        end
        step(1'b0, 1'b0, 1'b0, 16'd0, 1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b0, 1'b0, 16'd0, 1'b0, 1'b0, 1'b1);

        // Auto-reload, prescale 3, load 2: expiry every 8 cycles
        step(1'b0, 1'b0, 1'b1, 16'd0, 1'b0, 1'b0, 1'b0);
        prescale = 8'd3; load_val = 16'd2; auto_reload = 1'b1;
        step(1'b1, 1'b0, 1'b0, 16'd2, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 16'd2, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0, 16'd1, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 16'd2, 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 16'd2, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0, 16'd1, 1'b1, 1'b0, 1'b1);
        // irq_clr coincident with expiry: set wins
        step(1'b0, 1'b0, 1'b1, 16'd2, 1'b1, 1'b1, 1'b1);
        step(1'b0, 1'b0, 1'b1, 16'd2, 1'b1, 1'b0, 1'b0);

        // stop and start together: stop wins, then start alone restarts
        step(1'b1, 1'b1, 1'b0, 16'd2, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 16'd2, 1'b0, 1'b0, 1'b0);
        load_val = 16'd9;
        step(1'b1, 1'b0, 1'b0, 16'd9, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 16'd9, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 16'd9, 1'b0, 1'b0, 1'b0);

        // stop on an edge that would expire: no pulse, count holds
        prescale = 8'd0; load_val = 16'd1; auto_reload = 1'b0;
        step(1'b1, 1'b0, 1'b0, 16'd1, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 16'd1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 16'd1, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 16'd0, 1'b0, 1'b1, 1'b1);

        // start with load_val 0 is ignored, in IDLE and in RUN
        load_val = 16'd0;
        step(1'b1, 1'b0, 1'b0, 16'd0, 1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b0, 16'd0, 1'b0, 1'b0, 1'b1);
        load_val = 16'd2;
        step(1'b1, 1'b0, 1'b0, 16'd2, 1'b1, 1'b0, 1'b1);
        load_val = 16'd0;
        step(1'b1, 1'b0, 1'b0, 16'd2, 1'b1, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 16'd1, 1'b1, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 16'd0, 1'b0, 1'b1, 1'b1);

        // Auto-reload with load_val 0 at expiry: count 0 and IDLE
        auto_reload = 1'b1; load_val = 16'd3;
        step(1'b1, 1'b0, 1'b0, 16'd3, 1'b1, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 16'd2, 1'b1, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 16'd1, 1'b1, 1'b0, 1'b1);
        load_val = 16'd0;
        step(1'b0, 1'b0, 1'b0, 16'd0, 1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b0, 1'b0, 16'd0, 1'b0, 1'b0, 1'b1);

        // Live prescale reduction below the prescaler count ticks immediately
        auto_reload = 1'b0; prescale = 8'd7; load_val = 16'd2;
        step(1'b1, 1'b0, 1'b0, 16'd2, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0, 16'd2, 1'b1, 1'b0, 1'b1);
        prescale = 8'd1;
        step(1'b0, 1'b0, 1'b0, 16'd1, 1'b1, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 16'd1, 1'b1, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 16'd0, 1'b0, 1'b1, 1'b1);

        // Asynchronous reset mid-run at count 7
        prescale = 8'd0; load_val = 16'd8;
        step(1'b1, 1'b0, 1'b0, 16'd8, 1'b1, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 16'd7, 1'b1, 1'b0, 1'b1);
        #1;
        clr_b = 1'b0;
        check_async(16'd0, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        @(negedge clk);
        clr_b = 1'b1;
        step(1'b0, 1'b0, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 16'd8, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 16'd7, 1'b1, 1'b0, 1'b0);

        @(posedge clk);
        #3;
        n_tests++;
        if (exp_q.size() != 0) begin
            n_failed++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_failed);
        $finish;
    end

endmodule
